// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with optional signed saturation and NZCV flags.
// The carry chain is cut into STAGES slices, one register stage per slice, under a global stall.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags
);

    localparam int SL  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] raw,
                                                input logic             neg,
                                                input logic             ovf);
        if (!ovf)
            return raw;
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic             w_adv;
    logic             w_vld  [STAGES];
    logic [WIDTH-1:0] w_a    [STAGES];
    logic [WIDTH-1:0] w_b    [STAGES];
    logic [WIDTH-1:0] w_sum  [STAGES];
    logic             w_cin  [STAGES];
    logic             w_sat  [STAGES];
    logic [WIDTH-1:0] w_nsum [STAGES];
    logic             w_cout [STAGES];

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_v;
    logic             w_sgn;

    logic             r_ovld;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;

    assign w_adv    = !r_ovld || out_ready;
    assign in_ready = w_adv;

    // Stage 0 inputs: B is inverted here for subtracts, so every later slice just adds.
    assign w_vld[0] = in_valid;
    assign w_a[0]   = in_a;
    assign w_b[0]   = in_op[0] ? ~in_b : in_b;
    assign w_cin[0] = in_op[1] ? in_op[0] : in_cin;
    assign w_sum[0] = '0;
    assign w_sat[0] = in_op[1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SL:0] w_slice;

        assign w_slice = {1'b0, w_a[s][s*SL +: SL]} + {1'b0, w_b[s][s*SL +: SL]}
                       + {{SL{1'b0}}, w_cin[s]};
        assign w_cout[s] = w_slice[SL];

        always_comb begin
            w_nsum[s] = w_sum[s];
            w_nsum[s][s*SL +: SL] = w_slice[SL-1:0];
        end

        if (s < STAGES - 1) begin : g_reg
            logic             r_vld_p;
            logic [WIDTH-1:0] r_a_p;
            logic [WIDTH-1:0] r_b_p;
            logic [WIDTH-1:0] r_sum_p;
            logic             r_c_p;
            logic             r_sat_p;

            // Stage s -> s+1 boundary: partial sum, carry and untouched operand bits move together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_vld_p <= 1'b0;
                else if (w_adv)
                    r_vld_p <= w_vld[s];
            end

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a_p   <= w_a[s];
                    r_b_p   <= w_b[s];
                    r_sum_p <= w_nsum[s];
                    r_c_p   <= w_slice[SL];
                    r_sat_p <= w_sat[s];
                end
            end

            assign w_vld[s+1] = r_vld_p;
            assign w_a[s+1]   = r_a_p;
            assign w_b[s+1]   = r_b_p;
            assign w_sum[s+1] = r_sum_p;
            assign w_cin[s+1] = r_c_p;
            assign w_sat[s+1] = r_sat_p;
        end
    end

    // Last stage: overflow from operand signs vs result sign, then optional clamp.
    assign w_raw = w_nsum[STAGES-1];
    assign w_c   = w_cout[STAGES-1];
    assign w_sgn = w_a[STAGES-1][MSB];
    assign w_v   = (w_sgn == w_b[STAGES-1][MSB]) && (w_raw[MSB] != w_sgn);
    assign w_y   = sat_fn(w_raw, w_sgn, w_v && w_sat[STAGES-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovld  <= 1'b0;
            r_y     <= '0;
            r_flags <= '0;
        end else if (w_adv) begin
            r_ovld  <= w_vld[STAGES-1];
            r_y     <= w_y;
            r_flags <= {w_y[MSB], (w_y == '0), w_c, w_v};
        end
    end

    assign out_valid = r_ovld;
    assign out_y     = r_y;
    assign out_flags = r_flags;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed cases on a 16/2 instance plus random sweeps of 8/1, 16/4, 32/4.
module tb_pipe_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    bit sweep_go = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Whole-word reference: returns {N,Z,C,V, y[31:0]}.
    function automatic logic [35:0] model(input int w, input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        logic [63:0] mask, aa, bb, full, raw, y;
        logic c, v, am, bm;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'b0, a} & mask;
        bb   = op[0] ? (~{32'b0, b}) & mask : {32'b0, b} & mask;
        full = aa + bb + {63'b0, (op[1] ? op[0] : cin)};
        raw  = full & mask;
        c    = full[w];
        am   = aa[w-1];
        bm   = bb[w-1];
        v    = (am == bm) && (raw[w-1] != am);
        y    = (op[1] && v) ? (am ? (64'd1 << (w-1)) : (mask >> 1)) : raw;
        return {y[w-1], (y == 64'd0), c, v, y[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return m;
            2:       return m >> 1;
            3:       return (m >> 1) + 32'd1;
            4:       return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    logic        m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b1, m_cin = 1'b0;
    logic [1:0]  m_op = 2'b00;
    logic [15:0] m_a = '0, m_b = '0, m_y;
    logic [3:0]  m_flags;
    logic [19:0] m_q [$];
    int          m_qc [$];
    bit          m_ql [$];
    bit          m_lat = 1'b1;
    int          m_pops = 0;

    pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_a), .in_b(m_b), .in_op(m_op), .in_cin(m_cin),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_y(m_y), .out_flags(m_flags)
    );

    always @(negedge clk) begin : m_mon
        logic [19:0] e;
        int c;
        bit l;
        if (rst_n && m_out_valid && m_out_ready) begin
            m_pops++;
            if (m_q.size() == 0) begin
                check_eq("m_extra_output", 64'd1, 64'd0);
            end else begin
                e = m_q.pop_front();
                c = m_qc.pop_front();
                l = m_ql.pop_front();
                check_eq("m_result", {44'b0, m_flags, m_y}, {44'b0, e});
                if (l) check_eq("m_latency", cyc - c, 64'd2);
            end
        end
    end

    task automatic m_send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [3:0] ef, input logic [15:0] ey);
        int n;
        bit acc;
        m_in_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_cin = cin;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (m_in_ready) begin
                acc = 1'b1;
                m_q.push_back({ef, ey}); m_qc.push_back(cyc); m_ql.push_back(m_lat);
            end
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check_eq("m_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic m_send_rand();
        logic [1:0] op; logic [15:0] a, b; logic cin; logic [35:0] e;
        op = 2'($urandom_range(0, 3)); a = 16'(pick(16)); b = 16'(pick(16)); cin = 1'($urandom_range(0, 1));
        e = model(16, op, {16'b0, a}, {16'b0, b}, cin);
        m_send(op, a, b, cin, e[35:32], e[15:0]);
    endtask

    task automatic m_drain();
        int n;
        n = 0;
        while (m_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        #1;
        check_eq("m_drained", m_q.size(), 64'd0);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
        localparam int S = (g == 0) ? 1 : 4;

        logic         iv = 1'b0, ir, ov, ordy = 1'b1, cin = 1'b0;
        logic [1:0]   op = 2'b00;
        logic [W-1:0] a = '0, b = '0, y;
        logic [3:0]   fl;
        logic [35:0]  q [$];
        int           qc [$];
        bit           ql [$];
        bit           done = 1'b0;
        int           sent = 0;

        pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir),
            .in_a(a), .in_b(b), .in_op(op), .in_cin(cin),
            .out_valid(ov), .out_ready(ordy),
            .out_y(y), .out_flags(fl)
        );

        always @(negedge clk) begin : mon
            logic [35:0] e;
            int c;
            bit l;
            if (rst_n && ov && ordy) begin
                if (q.size() == 0) begin
                    check_eq("sw_extra_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    c = qc.pop_front();
                    l = ql.pop_front();
                    check_eq("sw_result", (64'(fl) << 32) | 64'(y), {28'b0, e});
                    if (l) check_eq("sw_latency", cyc - c, 64'(S));
                end
            end
        end

        task automatic run(input int upto, input bit stall);
            int n;
            n = 0;
            while (sent < upto && n < 2000) begin
                iv   = ($urandom_range(0, 4) != 0);
                ordy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                op   = 2'($urandom_range(0, 3));
                a    = W'(pick(W));
                b    = W'(pick(W));
                cin  = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (iv && ir) begin
                    q.push_back(model(W, op, 32'(a), 32'(b), cin));
                    qc.push_back(cyc);
                    ql.push_back(!stall);
                    sent++;
                end
                @(posedge clk); #1;
                n++;
            end
            iv = 1'b0; ordy = 1'b1;
            n = 0;
            while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
            #1;
            check_eq("sw_drained", q.size(), 64'd0);
            check_eq("sw_count", sent, 64'(upto));
        endtask

        initial begin
            wait (sweep_go);
            @(posedge clk); #1;
            run(20, 1'b0);
            run(80, 1'b1);
            done = 1'b1;
        end
    end

    initial begin : main
        logic [15:0] held_y;
        logic [3:0]  held_f;
        int p0, n;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", m_out_valid, 64'd0);
        check_eq("rst_out_y", m_y, 64'd0);
        check_eq("rst_out_flags", m_flags, 64'd0);
        check_eq("rst_in_ready", m_in_ready, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        m_send(2'b00, 16'h00FF, 16'h0001, 1'b0, 4'b0000, 16'h0100);
        m_send(2'b00, 16'hFFFF, 16'h0001, 1'b0, 4'b0110, 16'h0000);
        m_send(2'b01, 16'h0005, 16'h0007, 1'b1, 4'b1000, 16'hFFFE);
        m_send(2'b10, 16'h7FFF, 16'h0001, 1'b0, 4'b0001, 16'h7FFF);
        m_send(2'b11, 16'h8000, 16'h0001, 1'b0, 4'b1011, 16'h8000);
        m_send(2'b00, 16'h1234, 16'h0001, 1'b1, 4'b0000, 16'h1236);
        m_send(2'b01, 16'h0005, 16'h0003, 1'b0, 4'b0010, 16'h0001);
        m_send(2'b01, 16'h0007, 16'h0007, 1'b1, 4'b0110, 16'h0000);
        m_send(2'b10, 16'h1000, 16'h2000, 1'b1, 4'b0000, 16'h3000);
        m_send(2'b10, 16'h8000, 16'hFFFF, 1'b1, 4'b1011, 16'h8000);
        m_send(2'b11, 16'h7FFF, 16'hFFFF, 1'b0, 4'b0001, 16'h7FFF);
        m_in_valid = 1'b0;
        m_drain();

        m_lat = 1'b0;
        p0 = m_pops;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                m_out_ready = 1'b0;
                held_y = m_y;
                held_f = m_flags;
                repeat (4) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", m_in_ready, 64'd0);
                    check_eq("stall_out_valid", m_out_valid, 64'd1);
                    check_eq("stall_hold", {44'b0, m_flags, m_y}, {44'b0, held_f, held_y});
                end
                @(posedge clk); #1;
                m_out_ready = 1'b1;
            end
            m_send_rand();
        end
        m_in_valid = 1'b0;
        m_drain();
        check_eq("stall_pop_count", m_pops - p0, 64'd8);
        m_lat = 1'b1;

        m_send_rand();
        m_send_rand();
        m_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", m_out_valid, 64'd0);
        check_eq("rst_mid_out_y", m_y, 64'd0);
        check_eq("rst_mid_out_flags", m_flags, 64'd0);
        m_q.delete(); m_qc.delete(); m_ql.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("rst_no_output", m_out_valid, 64'd0);
        end
        @(posedge clk); #1;
        m_send(2'b01, 16'h0100, 16'h0001, 1'b1, 4'b0010, 16'h00FF);
        m_in_valid = 1'b0;
        m_drain();

        sweep_go = 1'b1;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
            check_eq("sweep_timeout", 64'd0, 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
